// File: rtl/fifo_level_pkg.sv
// Shared constants, error-flag type and helper function for the FIFO slice.
package fifo_level_pkg;

  localparam int unsigned UART_DATA_WIDTH   = 8;
  localparam int unsigned FIFO_ADDR_WIDTH   = 4;
  localparam int unsigned LOWMEM_ADDR_WIDTH = 13;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_level_if.sv
// FIFO data/control/status bundle; the FIFO is the slave, its user the master.
interface fifo_level_if import fifo_level_pkg::*; #(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  flush;
  logic                  fifo_write;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  clear_err;

  modport master (
    output flush, fifo_write, fifo_data_in, fifo_read, clear_err,
    input  fifo_data_out, full, empty, level, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, fifo_write, fifo_data_in, fifo_read, clear_err,
    output fifo_data_out, full, empty, level, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_level_mem.sv
// 1W/1R storage. REG_READ=1 gives a registered read port (BRAM style), 0 a combinational one.
module fifo_level_mem import fifo_level_pkg::*; #(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned REG_READ   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_rdata;

    // Output register loads only on an accepted pop, otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rdata <= '0;
      end else if (i_re) begin
        r_rdata <= r_mem[i_raddr];
      end
    end

    assign o_rdata = r_rdata;
  end else begin : g_comb_read
    logic w_unused_rd;
    assign w_unused_rd = i_re ^ reset_n;
    assign o_rdata     = r_mem[i_raddr];
  end

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO controller: pointers, registered level/threshold flags, sticky errors, flush.
module fifo_level import fifo_level_pkg::*; #(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int unsigned FWFT         = 1,
  parameter int unsigned AFULL_LEVEL  = 12,
  parameter int unsigned AEMPTY_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fifo_level_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, r_level;
  logic                  r_full, r_empty, r_afull, r_aempty;
  fifo_err_t             r_err;

  logic                  w_wr_acc, w_rd_acc;
  logic [ADDR_WIDTH:0]   w_wr_ptr_d, w_rd_ptr_d, w_level_d;
  fifo_err_t             w_err_d;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Accept/reject decisions and next state; flush overrides both ports and sets no errors.
  always_comb begin
    w_rd_acc = bus.fifo_read & ~r_empty & ~bus.flush;
    // A full FIFO still takes a write when a pop frees the slot on the same edge.
    w_wr_acc = bus.fifo_write & (~r_full | w_rd_acc) & ~bus.flush;

    if (bus.flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_level_d  = '0;
    end else begin
      w_wr_ptr_d = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
      w_rd_ptr_d = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
      w_level_d  = r_level + {{ADDR_WIDTH{1'b0}}, w_wr_acc} - {{ADDR_WIDTH{1'b0}}, w_rd_acc};
    end

    // New error wins over clear_err in the same cycle.
    w_err_d.overflow  = (bus.fifo_write & r_full & ~w_rd_acc & ~bus.flush) |
                        (r_err.overflow & ~bus.clear_err);
    w_err_d.underflow = (bus.fifo_read & r_empty & ~bus.flush) |
                        (r_err.underflow & ~bus.clear_err);
  end

  // State and flags update together so flags always match the pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= (AFULL_LEVEL == 0);
      r_aempty <= 1'b1;
      r_err    <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_level  <= w_level_d;
      r_full   <= (w_level_d == LP_DEPTH);
      r_empty  <= (w_level_d == '0);
      r_afull  <= (32'(w_level_d) >= AFULL_LEVEL);
      r_aempty <= (32'(w_level_d) <= AEMPTY_LEVEL);
      r_err    <= w_err_d;
    end
  end

  fifo_level_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   ((FWFT == 0) ? 1 : 0)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.fifo_data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.fifo_data_out = w_rdata;
  assign bus.full          = r_full;
  assign bus.empty         = r_empty;
  assign bus.level         = r_level;
  assign bus.almost_full   = r_afull;
  assign bus.almost_empty  = r_aempty;
  assign bus.overflow      = r_err.overflow;
  assign bus.underflow     = r_err.underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench: a show-ahead instance (dut1) and a registered-read instance (dut0).
module tb_fifo_level;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  fifo_level_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();
  fifo_level_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();

  fifo_level #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1)
  );

  fifo_level #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)
  ) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if1.flush = 0; if1.fifo_write = 0; if1.fifo_read = 0; if1.clear_err = 0;
    if1.fifo_data_in = 8'h00;
    if0.flush = 0; if0.fifo_write = 0; if0.fifo_read = 0; if0.clear_err = 0;
    if0.fifo_data_in = 8'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    tick(); tick();
    checks++; if (if1.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", if1.empty); end
    checks++; if (if1.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", if1.full); end
    checks++; if (if1.level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", if1.level); end
    checks++; if (if1.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %b want 1", if1.almost_empty); end
    checks++; if (if1.almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b want 0", if1.almost_full); end
    checks++; if ({if1.overflow, if1.underflow} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {if1.overflow, if1.underflow}); end
    checks++; if (if0.fifo_data_out !== 8'h00) begin errors++; $display("FAIL rst_dout0: got %h want 00", if0.fifo_data_out); end
    reset_n = 1'b1;
    tick();
  endtask

  // 16 writes fill the FIFO; the 17th is dropped and flags overflow.
  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      if1.fifo_write = 1; if1.fifo_data_in = 8'(i);
      tick();
      checks++;
      if (if1.almost_full !== ((i + 1) >= 12)) begin
        errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, if1.almost_full, ((i + 1) >= 12));
      end
    end
    checks++; if (if1.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", if1.full); end
    checks++; if (if1.level !== 5'd16) begin errors++; $display("FAIL fill_level: got %0d want 16", if1.level); end
    checks++; if (if1.almost_empty !== 1'b0) begin errors++; $display("FAIL fill_aempty: got %b want 0", if1.almost_empty); end
    checks++; if (if1.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", if1.overflow); end
    if1.fifo_data_in = 8'hAA;
    tick();
    if1.fifo_write = 0;
    checks++; if (if1.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", if1.overflow); end
    checks++; if (if1.level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", if1.level); end
  endtask

  // Simultaneous read+write on a full FIFO, then drain across the pointer wrap.
  task automatic test_back_to_back();
    logic [7:0] exp;
    if1.clear_err = 1;
    tick();
    if1.clear_err = 0;
    checks++; if (if1.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", if1.overflow); end
    checks++; if (if1.fifo_data_out !== 8'h00) begin errors++; $display("FAIL head_before: got %h want 00", if1.fifo_data_out); end
    if1.fifo_read = 1; if1.fifo_write = 1; if1.fifo_data_in = 8'h55;
    tick();
    if1.fifo_read = 0; if1.fifo_write = 0;
    checks++; if (if1.level !== 5'd16) begin errors++; $display("FAIL rw_full_level: got %0d want 16", if1.level); end
    checks++; if (if1.overflow !== 1'b0) begin errors++; $display("FAIL rw_full_ovf: got %b want 0", if1.overflow); end
    checks++; if (if1.full !== 1'b1) begin errors++; $display("FAIL rw_full_full: got %b want 1", if1.full); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'h55;
      checks++;
      if (if1.fifo_data_out !== exp) begin
        errors++; $display("FAIL drain[%0d]: got %h want %h", i, if1.fifo_data_out, exp);
      end
      if1.fifo_read = 1;
      tick();
    end
    if1.fifo_read = 0;
    checks++; if (if1.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", if1.empty); end
    checks++; if (if1.level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", if1.level); end
    checks++; if (if1.underflow !== 1'b0) begin errors++; $display("FAIL drain_unf: got %b want 0", if1.underflow); end
  endtask

  task automatic test_fwft();
    if1.fifo_write = 1; if1.fifo_data_in = 8'h41;
    tick();
    if1.fifo_write = 0;
    checks++; if (if1.empty !== 1'b0) begin errors++; $display("FAIL fwft_empty: got %b want 0", if1.empty); end
    checks++; if (if1.fifo_data_out !== 8'h41) begin errors++; $display("FAIL fwft_dout: got %h want 41", if1.fifo_data_out); end
    checks++; if (if1.level !== 5'd1) begin errors++; $display("FAIL fwft_level: got %0d want 1", if1.level); end
    if1.fifo_read = 1;
    tick();
    checks++; if (if1.empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b want 1", if1.empty); end
    checks++; if (if1.underflow !== 1'b0) begin errors++; $display("FAIL fwft_pop_unf: got %b want 0", if1.underflow); end
    tick();
    if1.fifo_read = 0;
    checks++; if (if1.underflow !== 1'b1) begin errors++; $display("FAIL unf_set: got %b want 1", if1.underflow); end
    checks++; if (if1.level !== 5'd0) begin errors++; $display("FAIL unf_level: got %0d want 0", if1.level); end
    if1.clear_err = 1;
    tick();
    if1.clear_err = 0;
    checks++; if (if1.underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: got %b want 0", if1.underflow); end
    // Read+write while empty: write lands, read is rejected.
    if1.fifo_write = 1; if1.fifo_read = 1; if1.fifo_data_in = 8'h77;
    tick();
    if1.fifo_write = 0;
    checks++; if (if1.level !== 5'd1) begin errors++; $display("FAIL rw_empty_level: got %0d want 1", if1.level); end
    checks++; if (if1.underflow !== 1'b1) begin errors++; $display("FAIL rw_empty_unf: got %b want 1", if1.underflow); end
    checks++; if (if1.fifo_data_out !== 8'h77) begin errors++; $display("FAIL rw_empty_dout: got %h want 77", if1.fifo_data_out); end
    tick();
    // Clear and a fresh underflow in the same cycle: set wins.
    if1.clear_err = 1;
    tick();
    if1.fifo_read = 0;
    checks++; if (if1.underflow !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", if1.underflow); end
    tick();
    if1.clear_err = 0;
    checks++; if (if1.underflow !== 1'b0) begin errors++; $display("FAIL clr_after: got %b want 0", if1.underflow); end
  endtask

  task automatic test_reg_read();
    if0.fifo_write = 1; if0.fifo_data_in = 8'h10;
    tick();
    if0.fifo_data_in = 8'h20;
    tick();
    if0.fifo_write = 0;
    checks++; if (if0.level !== 5'd2) begin errors++; $display("FAIL reg_level: got %0d want 2", if0.level); end
    checks++; if (if0.fifo_data_out !== 8'h00) begin errors++; $display("FAIL reg_no_showahead: got %h want 00", if0.fifo_data_out); end
    if0.fifo_read = 1;
    tick();
    if0.fifo_read = 0;
    checks++; if (if0.fifo_data_out !== 8'h10) begin errors++; $display("FAIL reg_dout1: got %h want 10", if0.fifo_data_out); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if0.fifo_data_out !== 8'h10) begin
        errors++; $display("FAIL reg_hold[%0d]: got %h want 10", i, if0.fifo_data_out);
      end
    end
    if0.fifo_read = 1;
    tick();
    checks++; if (if0.fifo_data_out !== 8'h20) begin errors++; $display("FAIL reg_dout2: got %h want 20", if0.fifo_data_out); end
    tick();
    if0.fifo_read = 0;
    checks++; if (if0.fifo_data_out !== 8'h20) begin errors++; $display("FAIL reg_rej_hold: got %h want 20", if0.fifo_data_out); end
    checks++; if (if0.underflow !== 1'b1) begin errors++; $display("FAIL reg_unf: got %b want 1", if0.underflow); end
    if0.clear_err = 1;
    tick();
    if0.clear_err = 0;
  endtask

  task automatic test_flush();
    if1.fifo_read = 1;
    tick();
    if1.fifo_read = 0;
    for (int i = 0; i < 7; i++) begin
      if1.fifo_write = 1; if1.fifo_data_in = 8'(8'h30 + i);
      tick();
    end
    checks++; if (if1.level !== 5'd7) begin errors++; $display("FAIL pre_flush_level: got %0d want 7", if1.level); end
    if1.flush = 1; if1.fifo_data_in = 8'hEE;
    tick();
    if1.flush = 0; if1.fifo_write = 0;
    checks++; if (if1.level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", if1.level); end
    checks++; if (if1.empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", if1.empty); end
    checks++; if (if1.almost_empty !== 1'b1) begin errors++; $display("FAIL flush_aempty: got %b want 1", if1.almost_empty); end
    checks++; if (if1.overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b want 0", if1.overflow); end
    checks++; if (if1.underflow !== 1'b1) begin errors++; $display("FAIL flush_sticky: got %b want 1", if1.underflow); end
    if1.clear_err = 1;
    tick();
    if1.clear_err = 0;
    // Flush masks a read on an empty FIFO, so no underflow.
    if1.flush = 1; if1.fifo_read = 1;
    tick();
    if1.flush = 0; if1.fifo_read = 0;
    checks++; if (if1.underflow !== 1'b0) begin errors++; $display("FAIL flush_rd_unf: got %b want 0", if1.underflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      if1.fifo_write = 1; if1.fifo_data_in = 8'(8'h60 + i);
      if0.fifo_write = 1; if0.fifo_data_in = 8'(8'h60 + i);
      if0.fifo_read = (i >= 1);
      tick();
    end
    checks++; if (if1.level !== 5'd5) begin errors++; $display("FAIL mid_level: got %0d want 5", if1.level); end
    checks++; if (if0.fifo_data_out !== 8'h63) begin errors++; $display("FAIL mid_dout0: got %h want 63", if0.fifo_data_out); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (if1.level !== 5'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", if1.level); end
    checks++; if (if1.empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", if1.empty); end
    checks++; if (if1.almost_empty !== 1'b1) begin errors++; $display("FAIL arst_aempty: got %b want 1", if1.almost_empty); end
    checks++; if (if0.fifo_data_out !== 8'h00) begin errors++; $display("FAIL arst_dout0: got %h want 00", if0.fifo_data_out); end
    tick();
    checks++; if (if1.level !== 5'd0) begin errors++; $display("FAIL arst_hold: got %0d want 0", if1.level); end
    idle();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_back_to_back();
    test_fwft();
    test_reg_read();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
